// File: rtl/com_bus_arbiter_4core.sv
// Coherence-bus arbiter for four cache wrappers: round-robin proc grants, nested snoop grants
// and a hold watchdog that raises a sticky error on a hung owner.
module com_bus_arbiter_4core #(
    parameter int NUM_CORES = 4,
    parameter int MAX_HOLD  = 256,
    parameter int CNT_W     = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CORES-1:0] Com_Bus_Req_proc,
    input  logic [NUM_CORES-1:0] Com_Bus_Req_snoop,
    output logic [NUM_CORES-1:0] Com_Bus_Gnt_proc,
    output logic [NUM_CORES-1:0] Com_Bus_Gnt_snoop,
    output logic [1:0]           Bus_owner,
    output logic                 Bus_busy,
    output logic                 Arb_error
);

    // state      | meaning
    // IDLE       | no grant outstanding, arbitrate on next edge
    // PROC       | one core owns the bus for its own miss/upgrade
    // PROC_SNOOP | proc owner active plus a nested snoop responder
    // SNOOP      | only a snoop responder holds the bus
    typedef enum logic [1:0] {IDLE, PROC, PROC_SNOOP, SNOOP} state_t;

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

    state_t                 state, state_nxt;
    logic [NUM_CORES-1:0]   gp_nxt, gs_nxt;
    logic [1:0]             owner_nxt, rr_ptr, rr_nxt, pick_idx;
    logic                   pick_vld;
    logic [CNT_W-1:0]       wd_cnt, wd_nxt;
    logic [NUM_CORES-1:0]   owner_oh, snoop_other;
    logic                   owner_req, holder_req;

    assign owner_oh    = NUM_CORES'(1) << Bus_owner;
    assign owner_req   = |(Com_Bus_Req_proc & owner_oh);
    assign holder_req  = |(Com_Bus_Req_snoop & Com_Bus_Gnt_snoop);
    assign snoop_other = Com_Bus_Req_snoop & ~owner_oh;

    // Round-robin scan starting at rr_ptr.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = 2'd0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (Com_Bus_Req_proc[2'(rr_ptr + 2'(i))]) begin
                pick_vld = 1'b1;
                pick_idx = 2'(rr_ptr + 2'(i));
            end
        end
    end

    always_comb begin
        state_nxt = state;
        gp_nxt    = Com_Bus_Gnt_proc;
        gs_nxt    = Com_Bus_Gnt_snoop;
        owner_nxt = Bus_owner;
        rr_nxt    = rr_ptr;
        case (state)
            IDLE: begin
                gp_nxt = '0;
                gs_nxt = '0;
                if (|Com_Bus_Req_snoop) begin
                    state_nxt = SNOOP;
                    gs_nxt    = Com_Bus_Req_snoop & (~Com_Bus_Req_snoop + NUM_CORES'(1));
                end else if (pick_vld) begin
                    state_nxt = PROC;
                    gp_nxt    = NUM_CORES'(1) << pick_idx;
                    owner_nxt = pick_idx;
                end
            end
            PROC: begin
                if (!owner_req) begin
                    state_nxt = IDLE;
                    gp_nxt    = '0;
                    rr_nxt    = Bus_owner + 2'd1;
                end else if (|snoop_other) begin
                    state_nxt = PROC_SNOOP;
                    gs_nxt    = snoop_other & (~snoop_other + NUM_CORES'(1));
                end
            end
            PROC_SNOOP: begin
                // Both dropping together ends the whole transaction.
                if (!holder_req && !owner_req) begin
                    state_nxt = IDLE;
                    gp_nxt    = '0;
                    gs_nxt    = '0;
                    rr_nxt    = Bus_owner + 2'd1;
                end else if (!holder_req) begin
                    state_nxt = PROC;
                    gs_nxt    = '0;
                end else if (!owner_req) begin
                    state_nxt = SNOOP;
                    gp_nxt    = '0;
                    rr_nxt    = Bus_owner + 2'd1;
                end
            end
            SNOOP: begin
                if (!holder_req) begin
                    state_nxt = IDLE;
                    gs_nxt    = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                gp_nxt    = '0;
                gs_nxt    = '0;
            end
        endcase
    end

    // Watchdog counts cycles the current grant pattern has been visible.
    always_comb begin
        wd_nxt = wd_cnt;
        if (!(|(gp_nxt | gs_nxt)))
            wd_nxt = '0;
        else if ((gp_nxt != Com_Bus_Gnt_proc) || (gs_nxt != Com_Bus_Gnt_snoop))
            wd_nxt = CNT_W'(1);
        else if (wd_cnt != HOLD_LIM)
            wd_nxt = wd_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            Com_Bus_Gnt_proc  <= '0;
            Com_Bus_Gnt_snoop <= '0;
            Bus_owner         <= 2'd0;
            Bus_busy          <= 1'b0;
            Arb_error         <= 1'b0;
            rr_ptr            <= 2'd0;
            wd_cnt            <= '0;
        end else begin
            state             <= state_nxt;
            Com_Bus_Gnt_proc  <= gp_nxt;
            Com_Bus_Gnt_snoop <= gs_nxt;
            Bus_owner         <= owner_nxt;
            Bus_busy          <= |(gp_nxt | gs_nxt);
            rr_ptr            <= rr_nxt;
            wd_cnt            <= wd_nxt;
            if (wd_nxt == HOLD_LIM)
                Arb_error <= 1'b1;
        end
    end

endmodule

// File: doc/com_bus_arbiter_4core.md
Name: com_bus_arbiter_4core

Overview:
Arbiter for the shared coherence bus (Address_Com/Data_Bus_Com/BusRd/BusRdX/Invalidate) in the 4-core system. It collects Com_Bus_Req_proc and Com_Bus_Req_snoop from every cache_wrapper instance and returns one-hot Com_Bus_Gnt_proc/Com_Bus_Gnt_snoop. Proc grants rotate round-robin. A snoop grant nests inside an active proc ownership so that a snooping cache can supply or write back a line mid-transaction. A hold watchdog flags hung owners.

Parameters:
NUM_CORES, 4, number of cache_wrapper instances (design fixed at 4; 2-bit owner index)
MAX_HOLD, 256, max consecutive cycles any single grant may be held before Arb_error
CNT_W, 9, watchdog counter width; must satisfy 2^CNT_W > MAX_HOLD

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
Com_Bus_Req_proc  input  4  bit i = core i requests bus for its own processor miss/upgrade
Com_Bus_Req_snoop  input  4  bit i = core i requests bus to respond to a snooped transaction
Com_Bus_Gnt_proc  output  4  one-hot or zero; proc grant to core i
Com_Bus_Gnt_snoop  output  4  one-hot or zero; snoop grant to core i
Bus_owner  output  2  index of current proc owner (valid when Bus_busy)
Bus_busy  output  1  1 whenever any grant is asserted
Arb_error  output  1  sticky watchdog flag

Behaviour:
- All outputs registered. Reset: grants 4'b0000, Bus_owner 0, Bus_busy 0, Arb_error 0, rr_ptr 0, watchdog 0, state IDLE.
- rst is sampled every edge and overrides any state, including mid-ownership: all grants drop the cycle after rst is seen high.
- States: IDLE, PROC, PROC_SNOOP, SNOOP.
- IDLE:
  - Any Com_Bus_Req_snoop bit set -> SNOOP; grant the lowest-index snoop requester. Snoop has priority over proc.
  - Else any Com_Bus_Req_proc bit set -> PROC; grant the first requester found scanning rr_ptr, rr_ptr+1, ... mod 4.
  - Grant appears the edge after the request is sampled (1-cycle latency).
- PROC:
  - Owner's proc request drops -> IDLE; grant deasserts next edge; rr_ptr <= owner+1 mod 4.
  - Else a snoop request from a core other than the owner -> PROC_SNOOP; lowest-index such core gets the snoop grant; proc grant stays asserted.
  - The owner's own snoop request bit is ignored.
- PROC_SNOOP:
  - Snoop holder drops its request -> PROC; snoop grant clears next edge.
  - Owner's proc request drops while the snoop is active -> proc grant clears and state goes to SNOOP; the snoop grant is never cut early. rr_ptr still advances.
- SNOOP: holder drops its request -> IDLE.
- Re-arbitration: the cycle after returning to IDLE, a new grant can be issued. This gives a minimum one-cycle gap with no grant between owners.
- Invariants: popcount(Gnt_proc) <= 1; popcount(Gnt_snoop) <= 1; the same core never holds both grants.
- Bus_owner updates with each proc grant and holds its last value in IDLE.
- Watchdog:
  - Counts cycles the current snoop grant is held, or the proc grant if no snoop grant is active.
  - Clears on any grant change.
  - On reaching MAX_HOLD, Arb_error <= 1 (sticky until rst). Grants are not revoked.
  - Counter saturates.
- Requests that drop before being granted are simply not served; there is no latching.

Test Plan:
- Reset: hold rst 2 cycles with Req_proc=4'b1111 -> all grants 0, Arb_error 0. Release -> Gnt_proc=4'b0001 one cycle later, Bus_owner=0.
- Round-robin: Req_proc=4'b1111, each owner holds 3 cycles then drops for 1 cycle -> grant sequence cores 0,1,2,3,0, with a one-cycle gap between owners.
- Nested snoop: core 2 owns (PROC); Req_snoop=4'b0110 -> Gnt_snoop=4'b0010 next edge, Gnt_proc stays 4'b0100. Core 1 drops snoop -> Gnt_snoop=0, back in PROC.
- Owner drops mid-snoop: core 0 owns with snoop on core 3; core 0 drops proc -> Gnt_proc=0, Gnt_snoop=4'b1000 retained. Core 3 drops -> IDLE, next proc grant to core 1.
- Snoop priority in IDLE: Req_proc=4'b0001 and Req_snoop=4'b0100 arrive the same cycle -> Gnt_snoop=4'b0100 first; proc grant only after snoop completes.
- Watchdog and mid-op reset: MAX_HOLD=8, core 1 holds proc for 8 cycles -> Arb_error=1 and stays 1 after release. Assert rst while granted -> grants and Arb_error go 0 on the next edge.
